// File: rtl/activity_bitmap_drain_if.sv
// Bundles the set/step/drain control and status signals of the activity bitmap drain.
// The master side drives the requests and the consumer ready, and the slave side returns the status.
interface activity_bitmap_drain_if #(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
);
    logic             clear;
    logic             set_valid;
    logic [IDX_W-1:0] set_idx;
    logic             step;
    logic             step_err;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;
    logic             done;
    logic             pending_any;
    logic             busy;

    modport master (
        output clear, set_valid, set_idx, step, out_ready,
        input  step_err, out_valid, out_idx, done, pending_any, busy
    );

    modport slave (
        input  clear, set_valid, set_idx, step, out_ready,
        output step_err, out_valid, out_idx, done, pending_any, busy
    );
endinterface

// File: rtl/activity_bitmap_drain.sv
// Accumulates neuron indices into a pending bitmap; a step moves it to active, which drains MSB-first.
// out_idx/out_valid are combinational from state (0-cycle); one index per cycle under out_ready backpressure.
module activity_bitmap_drain #(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    activity_bitmap_drain_if.slave  bus
);
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] active_q,  active_d;
    logic             step_err_q, step_err_d;
    logic             done_q,     done_d;

    logic [IDX_W-1:0] msb_idx;
    logic [WIDTH-1:0] set_oh;
    logic [WIDTH-1:0] drain_oh;
    logic             handshake;
    logic             step_acc;

    // Later (higher) hits overwrite earlier ones, leaving the most significant set bit.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (active_q[i]) begin
                msb_idx = IDX_W'(i);
            end
        end
    end

    assign set_oh    = bus.set_valid ? (WIDTH'(1) << bus.set_idx) : '0;
    assign drain_oh  = WIDTH'(1) << msb_idx;
    assign handshake = (|active_q) && bus.out_ready;
    assign step_acc  = bus.step && (active_q == '0);

    always_comb begin
        pending_d  = pending_q;
        active_d   = active_q;
        step_err_d = 1'b0;
        done_d     = 1'b0;
        if (!bus.clear) begin
            // A handshake needs a non-empty active map, so it never coincides with an accepted step.
            if (handshake) begin
                active_d = active_q & ~drain_oh;
                done_d   = ((active_q & ~drain_oh) == '0);
            end
            if (step_acc) begin
                active_d  = pending_q | set_oh;
                pending_d = '0;
            end else begin
                pending_d = pending_q | set_oh;
            end
            step_err_d = bus.step && !step_acc;
        end else begin
            pending_d = '0;
            active_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            active_q   <= '0;
            step_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            active_q   <= active_d;
            step_err_q <= step_err_d;
            done_q     <= done_d;
        end
    end

    assign bus.out_valid   = |active_q;
    assign bus.busy        = |active_q;
    assign bus.out_idx     = msb_idx;
    assign bus.pending_any = |pending_q;
    assign bus.step_err    = step_err_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_activity_bitmap_drain.sv
// Randomized and directed bench for activity_bitmap_drain against a set/queue reference model.
module tb_activity_bitmap_drain;
    localparam int WIDTH = 16;
    localparam int IDX_W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    activity_bitmap_drain_if #(.WIDTH(WIDTH)) ifc ();

    activity_bitmap_drain #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending is a set of indices, active is a descending queue of indices.
    bit m_pend [WIDTH];
    int m_act [$];
    bit m_err;
    bit m_done;

    int acc_q [$];
    int done_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit pend_any();
        bit r = 1'b0;
        for (int i = 0; i < WIDTH; i++) r |= m_pend[i];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) m_pend[i] = 1'b0;
            m_act.delete();
            m_err = 1'b0;
            m_done = 1'b0;
        end else if (ifc.clear) begin
            for (int i = 0; i < WIDTH; i++) m_pend[i] = 1'b0;
            m_act.delete();
            m_err = 1'b0;
            m_done = 1'b0;
        end else begin
            bit hs;
            bit acc;
            hs  = (m_act.size() > 0) && ifc.out_ready;
            acc = ifc.step && (m_act.size() == 0);
            m_err  = ifc.step && !acc;
            m_done = 1'b0;
            if (hs) begin
                void'(m_act.pop_front());
                m_done = (m_act.size() == 0);
            end
            if (ifc.set_valid) m_pend[ifc.set_idx] = 1'b1;
            if (acc) begin
                for (int i = WIDTH - 1; i >= 0; i--) if (m_pend[i]) m_act.push_back(i);
                for (int i = 0; i < WIDTH; i++) m_pend[i] = 1'b0;
            end
        end
    end

    // Single compare point, half a cycle away from the active edge.
    always @(negedge clk) begin
        chk("out_valid",   int'(ifc.out_valid),   int'(m_act.size() > 0));
        chk("busy",        int'(ifc.busy),        int'(m_act.size() > 0));
        chk("pending_any", int'(ifc.pending_any), int'(pend_any()));
        chk("step_err",    int'(ifc.step_err),    int'(m_err));
        chk("done",        int'(ifc.done),        int'(m_done));
        if (m_act.size() > 0) chk("out_idx", int'(ifc.out_idx), m_act[0]);
        if (reset_n && !ifc.clear && ifc.out_valid && ifc.out_ready) acc_q.push_back(int'(ifc.out_idx));
        if (ifc.done) done_cnt++;
        if (ifc.step_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.clear = 1'b0;
        ifc.set_valid = 1'b0;
        ifc.set_idx = '0;
        ifc.step = 1'b0;
    endtask

    task automatic set_one(input int idx);
        ifc.set_valid = 1'b1;
        ifc.set_idx = IDX_W'(idx);
        tick();
        ifc.set_valid = 1'b0;
    endtask

    task automatic do_step();
        ifc.step = 1'b1;
        tick();
        ifc.step = 1'b0;
    endtask

    // Drain with ready high until out_valid drops, bounded by a cycle budget.
    task automatic drain_all(input string nm);
        int n = 0;
        ifc.out_ready = 1'b1;
        while (ifc.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_drain_timeout"}, int'(n < 40), 1);
        tick();
    endtask

    task automatic check_seq(input string nm, input int exp []);
        chk({nm, "_len"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk({nm, "_idx"}, (i < acc_q.size()) ? acc_q[i] : -1, exp[i]);
        end
    endtask

    initial begin
        int e1 [] = '{15, 9, 3, 0};
        int e2 [] = '{12, 5};
        int e3 [] = '{7, 2};
        int e4a [] = '{4};
        int e4b [] = '{11};
        int e5 [] = '{6};
        idle();
        ifc.out_ready = 1'b0;
        #12;
        chk("reset_valid", int'(ifc.out_valid), 0);
        chk("reset_idx", int'(ifc.out_idx), 0);
        chk("reset_pend", int'(ifc.pending_any), 0);
        reset_n = 1'b1;
        tick();

        // 1: basic descending drain
        set_one(3); set_one(9); set_one(15); set_one(0);
        chk("t1_pend_before", int'(ifc.pending_any), 1);
        acc_q.delete(); done_cnt = 0;
        ifc.out_ready = 1'b1;
        do_step();
        chk("t1_valid_rise", int'(ifc.out_valid), 1);
        chk("t1_first_idx", int'(ifc.out_idx), 15);
        chk("t1_pend_after", int'(ifc.pending_any), 0);
        drain_all("t1");
        check_seq("t1", e1);
        chk("t1_done_cnt", done_cnt, 1);

        // 2: backpressure stall
        ifc.out_ready = 1'b0;
        set_one(12); set_one(5);
        do_step();
        acc_q.delete(); done_cnt = 0;
        repeat (4) begin
            chk("t2_stall_valid", int'(ifc.out_valid), 1);
            chk("t2_stall_idx", int'(ifc.out_idx), 12);
            tick();
        end
        drain_all("t2");
        check_seq("t2", e2);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: set during accepted step
        set_one(2);
        acc_q.delete();
        ifc.set_valid = 1'b1; ifc.set_idx = IDX_W'(7);
        do_step();
        ifc.set_valid = 1'b0;
        chk("t3_pend", int'(ifc.pending_any), 0);
        drain_all("t3");
        check_seq("t3", e3);

        // 4: rejected step, then deferred set
        ifc.out_ready = 1'b0;
        set_one(4);
        do_step();
        err_cnt = 0;
        ifc.set_valid = 1'b1; ifc.set_idx = IDX_W'(11);
        do_step();
        ifc.set_valid = 1'b0;
        chk("t4_err_pulse", int'(ifc.step_err), 1);
        chk("t4_idx_kept", int'(ifc.out_idx), 4);
        tick();
        chk("t4_err_clear", int'(ifc.step_err), 0);
        chk("t4_err_cnt", err_cnt, 1);
        acc_q.delete();
        drain_all("t4a");
        check_seq("t4a", e4a);
        acc_q.delete();
        do_step();
        drain_all("t4b");
        check_seq("t4b", e4b);

        // 5: duplicate sets
        ifc.out_ready = 1'b0;
        set_one(6); set_one(6); set_one(6);
        do_step();
        set_one(6);
        acc_q.delete();
        drain_all("t5a");
        check_seq("t5a", e5);
        acc_q.delete();
        do_step();
        drain_all("t5b");
        check_seq("t5b", e5);

        // 6: clear and async reset mid-drain
        set_one(10); set_one(1);
        ifc.out_ready = 1'b1;
        do_step();
        tick();
        done_cnt = 0; err_cnt = 0;
        ifc.clear = 1'b1;
        tick();
        ifc.clear = 1'b0;
        chk("t6_clr_valid", int'(ifc.out_valid), 0);
        chk("t6_clr_pend", int'(ifc.pending_any), 0);
        tick(); tick();
        chk("t6_clr_done", done_cnt, 0);
        chk("t6_clr_err", err_cnt, 0);
        set_one(10); set_one(1);
        do_step();
        ifc.set_valid = 1'b1; ifc.set_idx = IDX_W'(8);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(ifc.out_valid), 0);
        chk("t6_rst_pend", int'(ifc.pending_any), 0);
        tick();
        ifc.set_valid = 1'b0;
        reset_n = 1'b1;
        tick(); tick();
        chk("t6_rst_done", done_cnt, 0);
        chk("t6_rst_err", err_cnt, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            ifc.set_valid = ($urandom_range(0, 2) != 0);
            ifc.set_idx = IDX_W'($urandom_range(0, WIDTH - 1));
            ifc.step = ($urandom_range(0, 7) == 0);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            ifc.clear = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/activity_bitmap_drain.md
Name: activity_bitmap_drain

Overview:
- Neuron activity tracker: the write side of the set-bit encoders.
- Decodes incoming neuron indices to one-hot and accumulates them into a pending bitmap for the next timestep.
- On a step command, the pending bitmap moves to an active bitmap.
- The active bitmap is drained one index at a time, highest index first, over a valid/ready handshake; each bit clears as it is consumed.

Parameters:
- WIDTH, 16, bitmap width; legal values 8, 16, 32 only.
- IDX_W, $clog2(WIDTH), index width; derived, never overridden.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of both bitmaps.
- set_valid  input  1  mark set_idx active for next timestep; always accepted.
- set_idx  input  IDX_W  neuron index to mark.
- step  input  1  single-cycle timestep advance request.
- step_err  output  1  one-cycle pulse: step rejected.
- out_valid  output  1  active bitmap non-empty.
- out_idx  output  IDX_W  highest set index in active bitmap.
- out_ready  input  1  consumer accepts out_idx.
- done  output  1  one-cycle pulse: active bitmap drained to empty.
- pending_any  output  1  pending bitmap non-empty.
- busy  output  1  equals out_valid.

Behaviour:
- State is two WIDTH-bit registers: pending and active. The output flags step_err and done are registered.
- Reset (reset_n low, asynchronous): pending=0, active=0, step_err=0, done=0. Consequently out_valid=0, out_idx=0, busy=0, pending_any=0.
- out_valid = |active.
- out_idx = index of the most significant set bit of active; 0 when active==0.
  - Combinational from the active register, so it is stable for the whole cycle.
- pending_any = |pending, combinational from the register.
- Set: on set_valid, pending[set_idx] <= 1 at the next edge.
  - Setting an already-set bit is idempotent; nothing is counted and no error is raised.
- Drain: when out_valid && out_ready, active[out_idx] <= 0 at the edge.
  - The next index is presented the following cycle; throughput is one index per cycle.
  - Every set bit is presented exactly once, in strictly descending order.
- done: asserted for exactly one cycle, in the cycle after the handshake that clears the last active bit.
  - No done when a step loads an empty pending bitmap.
  - No done on clear or reset.
- Step accepted (step && active==0):
  - active <= pending | (set_valid ? onehot(set_idx) : 0).
  - pending <= 0.
  - out_valid rises the next cycle when the loaded value is non-zero.
- Step rejected (step && active!=0): no state change; step_err=1 for the next cycle only.
- Simultaneous events within one cycle:
  - set + accepted step: the set lands in the new active, not in pending.
  - set + rejected step: the set lands in pending.
  - set + handshake: both take effect (different bitmaps).
  - step + handshake clearing the last bit: step is rejected, because active was non-zero at the sampling edge.
  - clear + anything: clear wins. Both bitmaps become 0; set, step and handshake are ignored; step_err=0 and done=0 next cycle.
- Reset mid-drain: all state is lost immediately. Outputs drop asynchronously and no done is issued.
- out_idx and out_valid are meaningful only together; consumers must not sample out_idx while out_valid=0.

Test Plan:
1. WIDTH=16; set idx 3, 9, 15, 0 on consecutive cycles; step; out_ready=1 -> out_valid rises 1 cycle after step. out_idx sequence is 15, 9, 3, 0 on consecutive cycles. done pulses once, the cycle after idx 0 is accepted. pending_any=0 after step.
2. Backpressure: active={12,5}, out_ready low 4 cycles then high -> out_idx holds 12 with out_valid=1 throughout the stall. Then 12, 5 are accepted on consecutive cycles; done pulses once.
3. Set idx 7 in the same cycle as an accepted step with pending={2} -> drained sequence is 7, 2. pending stays 0.
4. Step while active={4} -> step_err=1 for exactly one cycle; active unchanged. A subsequent set of idx 11 appears only after the next accepted step.
5. Duplicate set idx 6 three times, plus a set of idx 6 during the drain of an earlier step -> idx 6 drains once in the current step and once in the next step, never twice within one step.
6. Assert clear mid-drain (active={10,1}), then separately pull reset_n low asynchronously mid-drain with set_valid=1 -> both cases give out_valid=0 and pending_any=0. No done and no step_err pulse follows.
